// File: rtl/gb_apu_pkg.sv
// Shared APU constants and types for the frame sequencer and its event source.
package gb_apu_pkg;

    localparam int FS_STEPS             = 8;
    localparam int DEFAULT_CLK_PER_TICK = 8192;

    typedef logic [2:0] fs_step_t;

    localparam fs_step_t FS_STEP_ENV = 3'd7;

endpackage : gb_apu_pkg

// File: rtl/gb_div_event.sv
// DIV-APU event source: selects the DIV bit (or an internal prescaler),
// detects the falling edge and applies the power-on skip quirk.
module gb_div_event
    import gb_apu_pkg::*;
#(
    parameter int USE_INTERNAL_DIV = 0,
    parameter int CLK_PER_TICK     = DEFAULT_CLK_PER_TICK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic apu_enable,
    input  logic div_bit4,
    input  logic div_bit5,
    input  logic double_speed,
    output logic evt
);

    logic div_sel_s;
    logic div_q_r;
    logic en_q_r;
    logic skip_r;
    logic power_on_s;
    logic src_evt_s;
    logic raw_evt_s;

    assign div_sel_s  = double_speed ? div_bit5 : div_bit4;
    assign power_on_s = apu_enable & ~en_q_r;
    // Events only count once the enable has been seen for a full cycle.
    assign raw_evt_s  = src_evt_s & apu_enable & en_q_r;
    assign evt        = raw_evt_s & ~skip_r;

    // Source-bit history, enable history and skip-first-event flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q_r <= 1'b0;
            en_q_r  <= 1'b0;
            skip_r  <= 1'b0;
        end else begin
            div_q_r <= div_sel_s;
            en_q_r  <= apu_enable;
            if (!apu_enable) begin
                skip_r <= 1'b0;
            end else if (power_on_s) begin
                skip_r <= (USE_INTERNAL_DIV != 0) ? 1'b0 : div_sel_s;
            end else if (raw_evt_s) begin
                skip_r <= 1'b0;
            end else begin
                skip_r <= skip_r;
            end
        end
    end

    generate
        if (USE_INTERNAL_DIV != 0) begin : g_internal
            localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
            localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

            logic [PW-1:0] presc_r;

            assign src_evt_s = (presc_r == PRESC_MAX);

            // Prescaler: held at zero while powered down or on power-on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc_r <= '0;
                end else if (!apu_enable || power_on_s) begin
                    presc_r <= '0;
                end else if (presc_r == PRESC_MAX) begin
                    presc_r <= '0;
                end else begin
                    presc_r <= presc_r + PW'(1);
                end
            end
        end else begin : g_external
            assign src_evt_s = div_q_r & ~div_sel_s;
        end
    endgenerate

endmodule : gb_div_event

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: turns 512 Hz DIV-APU events into the 256/128/64 Hz
// length, sweep and envelope strobes.
module gb_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int USE_INTERNAL_DIV = 0,
    parameter int CLK_PER_TICK     = DEFAULT_CLK_PER_TICK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_enable,
    input  logic       div_bit4,
    input  logic       div_bit5,
    input  logic       double_speed,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_vol_env,
    output logic [2:0] step
);

    logic     evt_s;
    fs_step_t step_r;
    logic     len_r;
    logic     sweep_r;
    logic     env_r;

    gb_div_event #(
        .USE_INTERNAL_DIV (USE_INTERNAL_DIV),
        .CLK_PER_TICK     (CLK_PER_TICK)
    ) u_div_event (
        .clk          (clk),
        .rst_n        (rst_n),
        .apu_enable   (apu_enable),
        .div_bit4     (div_bit4),
        .div_bit5     (div_bit5),
        .double_speed (double_speed),
        .evt          (evt_s)
    );

    // Step counter and strobe decode; power-off overrides any pending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r  <= 3'd0;
            len_r   <= 1'b0;
            sweep_r <= 1'b0;
            env_r   <= 1'b0;
        end else if (!apu_enable) begin
            step_r  <= 3'd0;
            len_r   <= 1'b0;
            sweep_r <= 1'b0;
            env_r   <= 1'b0;
        end else if (evt_s) begin
            len_r   <= ~step_r[0];
            sweep_r <= (step_r[1:0] == 2'b10);
            env_r   <= (step_r == FS_STEP_ENV);
            step_r  <= step_r + 3'd1;
        end else begin
            step_r  <= step_r;
            len_r   <= 1'b0;
            sweep_r <= 1'b0;
            env_r   <= 1'b0;
        end
    end

    assign clk_length_ctr = len_r;
    assign clk_sweep      = sweep_r;
    assign clk_vol_env    = env_r;
    assign step           = step_r;

endmodule : gb_frame_sequencer

// File: tb/tb_gb_frame_sequencer.sv
// Scoreboard bench for gb_frame_sequencer: an external-DIV instance and an
// internal-prescaler instance (CLK_PER_TICK=4) share clock and reset.
module tb_gb_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_ext = 1'b0;
    logic en_int = 1'b0;
    logic div_bit4 = 1'b0;
    logic div_bit5 = 1'b0;
    logic double_speed = 1'b0;

    logic       l_e, s_e, v_e;
    logic [2:0] st_e;
    logic       l_i, s_i, v_i;
    logic [2:0] st_i;

    always #5 clk = ~clk;

    gb_frame_sequencer #(.USE_INTERNAL_DIV(0), .CLK_PER_TICK(8192)) dut_ext (
        .clk(clk), .rst_n(rst_n), .apu_enable(en_ext),
        .div_bit4(div_bit4), .div_bit5(div_bit5), .double_speed(double_speed),
        .clk_length_ctr(l_e), .clk_sweep(s_e), .clk_vol_env(v_e), .step(st_e)
    );

    gb_frame_sequencer #(.USE_INTERNAL_DIV(1), .CLK_PER_TICK(4)) dut_int (
        .clk(clk), .rst_n(rst_n), .apu_enable(en_int),
        .div_bit4(div_bit4), .div_bit5(div_bit5), .double_speed(double_speed),
        .clk_length_ctr(l_i), .clk_sweep(s_i), .clk_vol_env(v_i), .step(st_i)
    );

    typedef struct {
        logic       l;
        logic       s;
        logic       e;
        logic [2:0] st;
        int         cyc;
    } exp_t;

    exp_t q_ext[$];
    exp_t q_int[$];

    int tests = 0;
    int fails = 0;
    int m_step = 0;
    bit m_skip = 1'b0;
    int n_len = 0, n_sw = 0, n_env = 0;
    int int_cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(ref exp_t q[$], input logic l, input logic s, input logic e,
                            input logic [2:0] st, input int cyc);
        exp_t x;
        x.l = l; x.s = s; x.e = e; x.st = st; x.cyc = cyc;
        q.push_back(x);
    endtask

    // Reference step model for the external instance.
    task automatic predict_event();
        logic [2:0] s;
        if (m_skip) begin
            m_skip = 1'b0;
        end else begin
            s = 3'(m_step);
            if (s[0] == 1'b0 || s == 3'd7)
                push_exp(q_ext, ~s[0], (s == 3'd2 || s == 3'd6), (s == 3'd7), s + 3'd1, 0);
            m_step = (m_step + 1) % 8;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full period of the chosen DIV bit; the falling edge is the event.
    task automatic ext_edge(input bit use5, input bit expect_evt);
        if (use5) div_bit5 = 1'b1; else div_bit4 = 1'b1;
        wait_cyc(16);
        if (use5) div_bit5 = 1'b0; else div_bit4 = 1'b0;
        if (expect_evt) predict_event();
        wait_cyc(16);
    endtask

    // External monitor: any strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (l_e === 1'b1 || s_e === 1'b1 || v_e === 1'b1)) begin
            exp_t x;
            if (l_e) n_len++;
            if (s_e) n_sw++;
            if (v_e) n_env++;
            if (q_ext.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ext_unexpected_strobe: got len=%0b sweep=%0b env=%0b step=%0d expected none",
                         l_e, s_e, v_e, st_e);
            end else begin
                x = q_ext.pop_front();
                chk("ext_strobes", int'({l_e, s_e, v_e}), int'({x.l, x.s, x.e}));
                chk("ext_step", int'(st_e), int'(x.st));
            end
        end
    end

    always @(posedge clk) if (en_int) int_cyc++;

    // Internal-mode monitor also checks the cycle of each strobe.
    always @(negedge clk) begin
        if (rst_n && (l_i === 1'b1 || s_i === 1'b1 || v_i === 1'b1)) begin
            exp_t x;
            if (q_int.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL int_unexpected_strobe: got len=%0b sweep=%0b env=%0b cyc=%0d expected none",
                         l_i, s_i, v_i, int_cyc);
            end else begin
                x = q_int.pop_front();
                chk("int_strobes", int'({l_i, s_i, v_i}), int'({x.l, x.s, x.e}));
                chk("int_step", int'(st_i), int'(x.st));
                chk("int_cycle", int_cyc, x.cyc);
            end
        end
    end

    initial begin
        int n0;
        en_ext = 1'b1;
        #12;
        chk("reset_step_ext", int'(st_e), 0);
        chk("reset_strobes_ext", int'({l_e, s_e, v_e}), 0);
        chk("reset_step_int", int'(st_i), 0);
        chk("reset_strobes_int", int'({l_i, s_i, v_i}), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);

        // Normal speed: 16 falling edges.
        m_step = 0; m_skip = 1'b0;
        for (int i = 0; i < 16; i++) ext_edge(1'b0, 1'b1);
        chk("t1_len_total", n_len, 8);
        chk("t1_sweep_total", n_sw, 4);
        chk("t1_env_total", n_env, 2);
        chk("t1_step_end", int'(st_e), 0);

        // Power-on with the DIV bit high: first edge is swallowed.
        en_ext = 1'b0;
        div_bit4 = 1'b1;
        wait_cyc(4);
        chk("t2_step_off", int'(st_e), 0);
        en_ext = 1'b1;
        m_step = 0; m_skip = 1'b1;
        wait_cyc(4);
        n0 = n_len;
        ext_edge(1'b0, 1'b1);
        chk("t2_step_after_skip", int'(st_e), 0);
        ext_edge(1'b0, 1'b1);
        chk("t2_step_edge2", int'(st_e), 1);
        ext_edge(1'b0, 1'b1);
        chk("t2_step_edge3", int'(st_e), 2);
        chk("t2_len_count", n_len - n0, 1);

        // Power gating from step 5.
        for (int i = 0; i < 3; i++) ext_edge(1'b0, 1'b1);
        chk("t3_step5", int'(st_e), 5);
        en_ext = 1'b0;
        m_step = 0;
        wait_cyc(2);
        chk("t3_step_off", int'(st_e), 0);
        for (int i = 0; i < 2; i++) ext_edge(1'b0, 1'b0);
        chk("t3_step_off_edges", int'(st_e), 0);
        en_ext = 1'b1;
        m_skip = 1'b0;
        wait_cyc(3);
        ext_edge(1'b0, 1'b1);
        chk("t3_step_reenable", int'(st_e), 1);
        chk("t3_queue_empty", q_ext.size(), 0);

        // Double speed: div_bit5 drives, div_bit4 ignored.
        double_speed = 1'b1;
        wait_cyc(2);
        n0 = n_len;
        for (int i = 0; i < 8; i++) ext_edge(1'b1, 1'b1);
        chk("t4_step_ds", int'(st_e), 1);
        chk("t4_len_ds", n_len - n0, 4);
        for (int i = 0; i < 3; i++) ext_edge(1'b0, 1'b0);
        chk("t4_bit4_ignored", int'(st_e), 1);
        double_speed = 1'b0;
        wait_cyc(2);

        // Internal prescaler, CLK_PER_TICK=4: event k strobes at cycle 4k+1.
        int_cyc = 0;
        push_exp(q_int, 1'b1, 1'b0, 1'b0, 3'd1, 5);
        push_exp(q_int, 1'b1, 1'b1, 1'b0, 3'd3, 13);
        push_exp(q_int, 1'b1, 1'b0, 1'b0, 3'd5, 21);
        push_exp(q_int, 1'b1, 1'b1, 1'b0, 3'd7, 29);
        push_exp(q_int, 1'b0, 1'b0, 1'b1, 3'd0, 33);
        push_exp(q_int, 1'b1, 1'b0, 1'b0, 3'd1, 37);
        en_int = 1'b1;
        wait_cyc(40);
        chk("t5_int_step", int'(st_i), 1);
        chk("t5_int_queue_empty", q_int.size(), 0);
        en_int = 1'b0;
        wait_cyc(2);
        chk("t5_int_step_off", int'(st_i), 0);

        // Async reset during an envelope strobe.
        while (m_step != 7) ext_edge(1'b0, 1'b1);
        div_bit4 = 1'b1;
        wait_cyc(16);
        div_bit4 = 1'b0;
        @(posedge clk);
        #2;
        chk("t6_env_high", int'(v_e), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_strobes", int'({l_e, s_e, v_e}), 0);
        chk("t6_reset_step", int'(st_e), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        m_step = 0; m_skip = 1'b0;
        wait_cyc(3);
        ext_edge(1'b0, 1'b1);
        chk("t6_resume_step", int'(st_e), 1);
        chk("t6_queue_empty", q_ext.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_gb_frame_sequencer
